// File: rtl/clk_div_bank.sv
// clk_div_bank
//
// Multi-channel programmable clock divider. Each channel divides in_clk by an
// arbitrary integer ratio D and produces a registered divided clock plus a
// one-cycle tick at the start of every period. New ratios are staged in a
// pending register and only take effect at a period boundary, so the divided
// clock never sees a truncated or stretched period from a ratio change.
//
// Parameters
//   CHANNELS   number of independent channels (1..16)
//   DIV_WIDTH  width of each divide ratio
//   RESET_DIV  active ratio of every channel after reset
//
// Ports
//   in_clk     sole clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   enable     per-channel run enable
//   sync       common strobe that restarts every running channel at phase 0
//   load       per-channel strobe capturing a new ratio from div_value
//   div_value  packed ratios, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   out_clk    registered divided clocks
//   tick       one-cycle pulse at the start of each period
//   pending    a loaded ratio is waiting for the next period boundary
//   applied    one-cycle pulse when a pending ratio becomes active
module clk_div_bank #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic                          in_clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           enable,
  input  logic                          sync,
  input  logic [CHANNELS-1:0]           load,
  input  logic [CHANNELS*DIV_WIDTH-1:0] div_value,
  output logic [CHANNELS-1:0]           out_clk,
  output logic [CHANNELS-1:0]           tick,
  output logic [CHANNELS-1:0]           pending,
  output logic [CHANNELS-1:0]           applied
);

  localparam logic [DIV_WIDTH-1:0] One       = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] ResetDiv  = DIV_WIDTH'(RESET_DIV);
  // Starting at D-1 makes the phase counter look like the last cycle of a
  // period; the restart flag forces the first enabled edge to be a wrap anyway.
  localparam logic [DIV_WIDTH-1:0] ResetPhase = (RESET_DIV == 0) ? '0 : ResetDiv - One;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch

    // Channel state
    logic [DIV_WIDTH-1:0] r_div;      // active ratio D
    logic [DIV_WIDTH-1:0] r_phase;    // phase counter m
    logic [DIV_WIDTH-1:0] r_pval;     // pending ratio P
    logic                 r_pflag;    // P is waiting to be applied
    logic                 r_restart;  // next enabled edge must start a period
    logic                 r_out_clk;
    logic                 r_tick;
    logic                 r_applied;

    // Next-state
    logic [DIV_WIDTH-1:0] w_div_nxt;
    logic [DIV_WIDTH-1:0] w_phase_nxt;
    logic [DIV_WIDTH-1:0] w_pval_nxt;
    logic                 w_pflag_nxt;
    logic                 w_restart_nxt;
    logic                 w_out_nxt;
    logic                 w_tick_nxt;
    logic                 w_applied_nxt;
    logic                 w_wrap;
    logic [DIV_WIDTH-1:0] w_load_val;

    assign w_load_val = div_value[gi*DIV_WIDTH +: DIV_WIDTH];

    always_comb begin
      w_div_nxt     = r_div;
      w_phase_nxt   = r_phase;
      w_pval_nxt    = r_pval;
      w_pflag_nxt   = r_pflag;
      w_restart_nxt = r_restart;
      w_out_nxt     = 1'b0;
      w_tick_nxt    = 1'b0;
      w_applied_nxt = 1'b0;
      w_wrap        = 1'b0;

      if (enable[gi]) begin
        if (r_div == '0) begin
          // Stopped channel: take a pending ratio now but keep the outputs
          // low this edge; the restart flag makes the next edge a clean
          // period start, so the first period of the new ratio is full length.
          w_phase_nxt = '0;
          if (r_pflag) begin
            w_div_nxt     = r_pval;
            w_pflag_nxt   = 1'b0;
            w_applied_nxt = 1'b1;
            w_restart_nxt = 1'b1;
          end
        end else begin
          w_wrap = (r_phase == r_div - One) || r_restart || sync;
          if (w_wrap) begin
            if (r_pflag) begin
              w_div_nxt     = r_pval;
              w_pflag_nxt   = 1'b0;
              w_applied_nxt = 1'b1;
            end
            w_phase_nxt   = '0;
            w_restart_nxt = 1'b0;
            // Applying a ratio of 0 stops the channel on this very edge.
            w_tick_nxt    = (w_div_nxt != '0);
          end else begin
            w_phase_nxt = r_phase + One;
          end

          // Output is a function of the post-edge ratio and phase.
          if (w_div_nxt == One) begin
            w_out_nxt = 1'b1;
          end else if (w_div_nxt > One) begin
            w_out_nxt = (w_phase_nxt < (w_div_nxt >> 1));
          end
        end
      end else begin
        w_restart_nxt = 1'b1;
      end

      // Load after the wrap decision: a load on a wrap edge stays pending
      // for the following boundary, and a newer load overwrites an older one.
      if (load[gi]) begin
        w_pval_nxt  = w_load_val;
        w_pflag_nxt = 1'b1;
      end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div     <= ResetDiv;
        r_phase   <= ResetPhase;
        r_pval    <= '0;
        r_pflag   <= 1'b0;
        r_restart <= 1'b1;
        r_out_clk <= 1'b0;
        r_tick    <= 1'b0;
        r_applied <= 1'b0;
      end else begin
        r_div     <= w_div_nxt;
        r_phase   <= w_phase_nxt;
        r_pval    <= w_pval_nxt;
        r_pflag   <= w_pflag_nxt;
        r_restart <= w_restart_nxt;
        r_out_clk <= w_out_nxt;
        r_tick    <= w_tick_nxt;
        r_applied <= w_applied_nxt;
      end
    end

    assign out_clk[gi] = r_out_clk;
    assign tick[gi]    = r_tick;
    assign pending[gi] = r_pflag;
    assign applied[gi] = r_applied;

  end : g_ch

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned RD = 2;

  logic              in_clk;
  logic              rst_n;
  logic [CH-1:0]     enable;
  logic              sync;
  logic [CH-1:0]     load;
  logic [CH*DW-1:0]  div_value;
  logic [CH-1:0]     out_clk;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     pending;
  logic [CH-1:0]     applied;

  clk_div_bank #(
    .CHANNELS  (CH),
    .DIV_WIDTH (DW),
    .RESET_DIV (RD)
  ) dut (
    .in_clk    (in_clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sync      (sync),
    .load      (load),
    .div_value (div_value),
    .out_clk   (out_clk),
    .tick      (tick),
    .pending   (pending),
    .applied   (applied)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic [CH-1:0] oc;
    logic [CH-1:0] tk;
    logic [CH-1:0] pd;
    logic [CH-1:0] ap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rst_req;

  // Reference model: ratio, cycles left in the current period, pending value.
  int m_div   [CH];
  int m_left  [CH];
  int m_pval  [CH];
  bit m_pf    [CH];
  bit m_start [CH];  // next enabled edge starts a fresh period

  task automatic check(input string name, input logic [CH-1:0] got,
                       input logic [CH-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_div[c]   = RD;
      m_left[c]  = 0;
      m_pval[c]  = 0;
      m_pf[c]    = 1'b0;
      m_start[c] = 1'b1;
    end
  endfunction

  function automatic exp_t model_step();
    exp_t e;
    int   pos;
    e = '0;
    if (!rst_n) begin
      model_reset();
      return e;
    end
    for (int c = 0; c < CH; c++) begin
      if (enable[c]) begin
        if (m_div[c] == 0) begin
          if (m_pf[c]) begin
            m_div[c]   = m_pval[c];
            m_pf[c]    = 1'b0;
            e.ap[c]    = 1'b1;
            m_start[c] = 1'b1;
          end
        end else begin
          if (m_start[c] || sync || m_left[c] == 0) begin
            if (m_pf[c]) begin
              m_div[c] = m_pval[c];
              m_pf[c]  = 1'b0;
              e.ap[c]  = 1'b1;
            end
            m_start[c] = 1'b0;
            m_left[c]  = (m_div[c] > 0) ? m_div[c] - 1 : 0;
            e.tk[c]    = (m_div[c] > 0);
          end else begin
            m_left[c]--;
          end
          pos = m_div[c] - 1 - m_left[c];
          e.oc[c] = (m_div[c] == 1) || (m_div[c] >= 2 && pos < m_div[c] / 2);
        end
      end else begin
        m_start[c] = 1'b1;
      end
      if (load[c]) begin
        m_pval[c] = int'(div_value[c*DW +: DW]);
        m_pf[c]   = 1'b1;
      end
      e.pd[c] = m_pf[c];
    end
    return e;
  endfunction

  function automatic bit wrap_next(input int c);
    return (m_div[c] != 0) && (m_start[c] || m_left[c] == 0);
  endfunction

  // One stimulus edge: drive at the falling edge, queue the expected response.
  task automatic drive(input logic [CH-1:0] en, input logic sy,
                       input logic [CH-1:0] ld, input logic [CH*DW-1:0] dv);
    @(negedge in_clk);
    rst_n     = rst_req;
    enable    = en;
    sync      = sy;
    load      = ld;
    div_value = dv;
    exp_q.push_back(model_step());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive('1, 1'b0, '0, '0);
  endtask

  task automatic load_ch(input int c, input int v);
    logic [CH-1:0]    ld;
    logic [CH*DW-1:0] dv;
    ld = '0;
    dv = '0;
    ld[c] = 1'b1;
    dv[c*DW +: DW] = DW'(v);
    drive('1, 1'b0, ld, dv);
  endtask

  task automatic wait_wrap(input int c);
    int k;
    k = 0;
    while (!wrap_next(c) && k < 200) begin
      idle(1);
      k++;
    end
    if (!wrap_next(c)) begin
      n_cmp++;
      n_err++;
      $display("FAIL wrap_wait ch%0d: no boundary within %0d edges", c, k);
    end
  endtask

  task automatic async_reset(input int hold);
    @(posedge in_clk);
    #3;
    rst_n   = 1'b0;
    rst_req = 1'b0;
    #1;
    check("async_rst_out_clk", out_clk, '0);
    check("async_rst_tick", tick, '0);
    check("async_rst_pending", pending, '0);
    check("async_rst_applied", applied, '0);
    model_reset();
    idle(hold);
    rst_req = 1'b1;
  endtask

  // Monitor: every rising edge presents a new registered output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge in_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_clk", out_clk, e.oc);
        check("tick", tick, e.tk);
        check("pending", pending, e.pd);
        check("applied", applied, e.ap);
      end
    end
  end

  initial begin
    logic [CH-1:0]    en;
    logic [CH-1:0]    ld;
    logic [CH*DW-1:0] dv;
    int               v;

    rst_n     = 1'b0;
    rst_req   = 1'b0;
    enable    = '0;
    sync      = 1'b0;
    load      = '0;
    div_value = '0;
    model_reset();

    // Held in reset: outputs stay at their reset values.
    idle(2);
    rst_req = 1'b1;

    // First edge after release is a period start at the reset ratio.
    idle(1);
    @(posedge in_clk);
    #2;
    check("first_tick", tick, '1);
    check("first_out_clk", out_clk, '1);
    idle(8);

    // Ratio 5 loaded mid-period on ch0.
    idle(1);
    load_ch(0, 5);
    idle(16);

    // ch0=7, ch1=3 free-running, then a sync strobe.
    begin
      ld = 4'b0011;
      dv = '0;
      dv[0*DW +: DW] = DW'(7);
      dv[1*DW +: DW] = DW'(3);
      drive('1, 1'b0, ld, dv);
    end
    idle(25);
    drive('1, 1'b1, '0, '0);
    idle(45);

    // Stop ch2 with ratio 0, then restart it with ratio 1.
    load_ch(2, 0);
    idle(6);
    load_ch(2, 1);
    idle(6);

    // Last-write-wins, and a load on the wrap edge stays pending.
    load_ch(3, 8);
    wait_wrap(3);
    idle(1);
    wait_wrap(3);
    idle(1);
    load_ch(3, 4);
    load_ch(3, 6);
    wait_wrap(3);
    load_ch(3, 9);
    idle(14);

    // Enable dropped for three edges, then an asynchronous reset mid-cycle.
    for (int k = 0; k < 3; k++) drive('0, 1'b0, '0, '0);
    async_reset(2);
    idle(1);
    @(posedge in_clk);
    #2;
    check("rerelease_tick", tick, '1);
    check("rerelease_out_clk", out_clk, '1);
    idle(8);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      en = ($urandom_range(0, 19) == 0) ? CH'($urandom) : '1;
      ld = '0;
      dv = '0;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 24) == 0) ld[c] = 1'b1;
        if ($urandom_range(0, 199) == 0) v = int'($urandom_range(0, 65535));
        else if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10, 40));
        else v = int'($urandom_range(0, 9));
        dv[c*DW +: DW] = DW'(v);
      end
      drive(en, ($urandom_range(0, 39) == 0), ld, dv);
    end

    idle(2);
    @(posedge in_clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
